regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register data width.
REQ-002 SHALL provide parameter AW, default 5, index width; NREG = 2**AW registers.
REQ-003 SHALL provide parameter NRP, default 2, number of combinational read ports.
REQ-004 SHALL provide parameter SP_IDX, default 2, index of the stack-pointer register.
REQ-005 SHALL provide parameter SP_RESET, default 32'h8000_0000, reset value of register SP_IDX.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port rd_idx  input  NRP*AW  read indices, port p at bits [p*AW +: AW].
REQ-009 SHALL have port rd_data  output  NRP*XLEN  read data, port p at bits [p*XLEN +: XLEN].
REQ-010 SHALL have port rd_busy  output  NRP  register at rd_idx[p] awaits a pending write.
REQ-011 SHALL have ports wr0_valid/wr1_valid  input  1  write request.
REQ-012 SHALL have ports wr0_ready/wr1_ready  output  1  write accepted this cycle.
REQ-013 SHALL have ports wr0_idx/wr1_idx  input  AW, and wr0_data/wr1_data  input  XLEN.
REQ-014 SHALL have ports alloc_valid  input  1, alloc_idx  input  AW, alloc_ready  output  1: scoreboard reservation for an issued producer.
REQ-015 SHALL have port flush  input  1  clears all busy bits.

Function
REQ-016 SHALL update the register array and busy vector only on the rising edge of clk.
REQ-017 SHALL complete a write, wrN_valid && wrN_ready, at the next edge: reg[idx] <= data and busy[idx] <= 0.
REQ-018 SHALL drive wr0_ready = 1 whenever rstn = 1.
REQ-019 SHALL drive wr1_ready = 0 when wr0_valid && wr1_valid && wr0_idx == wr1_idx && idx != 0; otherwise wr1_ready = rstn. Port 1 stalls; port 0 wins.
REQ-020 SHALL treat index 0 as hardwired: reads return 0, rd_busy = 0, and writes and allocs are accepted but discarded.
REQ-021 SHALL drive rd_data[p] = reg[rd_idx[p]] combinationally, with zero-cycle read latency.
REQ-022 SHALL drive rd_busy[p] = busy[rd_idx[p]] from registered state.
REQ-023 SHALL drive alloc_ready = 0 when busy[alloc_idx] = 1 and no accepted write targets alloc_idx this cycle (WAW stall); otherwise alloc_ready = rstn.
REQ-024 SHALL set busy[alloc_idx] <= 1 at the next edge on alloc_valid && alloc_ready && alloc_idx != 0.
REQ-025 SHALL let alloc win when an accepted alloc and an accepted write hit the same index in one cycle: data is written and busy ends 1.
REQ-026 SHALL clear every busy bit at the next edge on flush = 1, overriding alloc; writes in that cycle still update data.
REQ-027 SHALL ignore wrN_idx, wrN_data and alloc_idx when the matching valid is 0.

Reset
REQ-028 SHALL, at a rising edge with rstn = 0, clear all registers to 0 except reg[SP_IDX] = SP_RESET, and clear all busy bits.
REQ-029 SHALL hold all ready outputs at 0 while rstn = 0; rd_data reflects the reset array.
REQ-030 SHALL give reset priority over any write, alloc or flush arriving in the same cycle.

Configuration
REQ-031 SHALL, with macro REGFILE_BYPASS_EN defined, forward accepted write data to rd_data[p] in the same cycle when wrN_idx == rd_idx[p] != 0, port 0 taking priority, and force rd_busy[p] = 0 for that read unless an alloc to the same index is accepted that cycle.
REQ-032 SHALL, without REGFILE_BYPASS_EN, return pre-write array contents and rd_busy, so new data is visible one cycle after the write.

Verification
REQ-033 SHALL check: reset, then read idx 2 and idx 5 -> 32'h8000_0000 and 0, rd_busy = 0, wr0_ready = wr1_ready = alloc_ready = 1.
REQ-034 SHALL check: wr0 and wr1 both to idx 7 (data A, B) -> wr1_ready = 0; reg7 = A next cycle; B is written one cycle later.
REQ-035 SHALL check: alloc idx 9, then read 9 -> rd_busy = 1; a second alloc 9 -> alloc_ready = 0; wr0 9 = 32'h1234 -> busy clears and reg9 = 32'h1234.
REQ-036 SHALL check: same-cycle alloc 9 and wr0 9 = 32'h55 -> reg9 = 32'h55 and busy9 = 1.
REQ-037 SHALL check: write idx 0 = 32'hFFFF_FFFF and alloc 0 -> read 0 returns 0 and rd_busy = 0; flush with busy 3, 4 set -> all busy clear next cycle.
REQ-038 SHALL check, with REGFILE_BYPASS_EN: wr0 idx 3 = 32'hABCD while reading 3 -> rd_data = 32'hABCD in that same cycle; without the macro -> the old value.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard, two write ports and an alloc port.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int              XLEN     = 32,
  parameter int              AW       = 5,
  parameter int              NRP      = 2,
  parameter int              SP_IDX   = 2,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'(32'h8000_0000)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRP*AW-1:0]   rd_idx,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                wr0_valid,
  output logic                wr0_ready,
  input  logic [AW-1:0]       wr0_idx,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_valid,
  output logic                wr1_ready,
  input  logic [AW-1:0]       wr1_idx,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_idx,
  output logic                alloc_ready,
  input  logic                flush
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;

  logic w_wr0_acc;
  logic w_wr1_acc;
  logic w_alloc_acc;
  logic w_wr_hits_alloc;
  logic w_wr_conflict;

  // Same-index dual write: port 0 wins, port 1 retries next cycle.
  assign w_wr_conflict = wr0_valid && wr1_valid && (wr0_idx == wr1_idx) && (wr0_idx != '0);

  assign wr0_ready = rstn;
  assign wr1_ready = rstn && !w_wr_conflict;

  assign w_wr0_acc = wr0_valid && wr0_ready;
  assign w_wr1_acc = wr1_valid && wr1_ready;

  assign w_wr_hits_alloc = (w_wr0_acc && (wr0_idx == alloc_idx)) ||
                           (w_wr1_acc && (wr1_idx == alloc_idx));

  // WAW stall unless a write retires the pending producer in this same cycle.
  assign alloc_ready = rstn && !(r_busy[alloc_idx] && !w_wr_hits_alloc);
  assign w_alloc_acc = alloc_valid && alloc_ready;

  for (genvar gp = 0; gp < NRP; gp++) begin : g_rd
    logic [AW-1:0] w_idx;
    logic          w_nz;
    assign w_idx = rd_idx[gp*AW +: AW];
    assign w_nz  = (w_idx != '0);
`ifdef REGFILE_BYPASS_EN
    logic w_hit0;
    logic w_hit1;
    assign w_hit0 = w_wr0_acc && (wr0_idx == w_idx) && w_nz;
    assign w_hit1 = w_wr1_acc && (wr1_idx == w_idx) && w_nz;
    assign rd_data[gp*XLEN +: XLEN] = !w_nz  ? '0       :
                                      w_hit0 ? wr0_data :
                                      w_hit1 ? wr1_data : r_regs[w_idx];
    assign rd_busy[gp] = !w_nz ? 1'b0 :
                         (w_hit0 || w_hit1) ? (w_alloc_acc && (alloc_idx == w_idx)) :
                         r_busy[w_idx];
`else
    assign rd_data[gp*XLEN +: XLEN] = w_nz ? r_regs[w_idx] : '0;
    assign rd_busy[gp]              = w_nz && r_busy[w_idx];
`endif
  end

  // Later assignments take priority: alloc overrides write-clear, flush overrides alloc.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr0_acc && (wr0_idx != '0)) begin
        r_regs[wr0_idx] <= wr0_data;
        r_busy[wr0_idx] <= 1'b0;
      end
      if (w_wr1_acc && (wr1_idx != '0)) begin
        r_regs[wr1_idx] <= wr1_data;
        r_busy[wr1_idx] <= 1'b0;
      end
      if (w_alloc_acc && (alloc_idx != '0)) begin
        r_busy[alloc_idx] <= 1'b1;
      end
      if (flush) begin
        r_busy <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, both bypass configurations).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  rd_idx;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [4:0]  wr0_idx, wr1_idx, alloc_idx;
  logic [31:0] wr0_data, wr1_data;
  logic        alloc_valid, alloc_ready, flush;

  int n_run  = 0;
  int n_fail = 0;

  regfile_mp dut (
    .clk(clk), .rstn(rstn), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_idx(wr0_idx), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_idx(wr1_idx), .wr1_data(wr1_data),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_ready(alloc_ready),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wr0_valid = 0; wr0_idx = 0; wr0_data = 0;
    wr1_valid = 0; wr1_idx = 0; wr1_data = 0;
    alloc_valid = 0; alloc_idx = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0; idle();
    wr0_valid = 1; wr0_idx = 5; wr0_data = 32'hDEAD_BEEF;
    alloc_valid = 1; alloc_idx = 6; flush = 1;
    #1;
    n_run++;
    if ({wr0_ready, wr1_ready, alloc_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 000", {wr0_ready, wr1_ready, alloc_ready});
    end
    tick(); tick();
    rstn = 1; idle(); rd_idx = {5'd5, 5'd2};
    #1;
    n_run++;
    if (rd_data[31:0] !== 32'h8000_0000) begin
      n_fail++; $display("FAIL reset_sp: got %h want 80000000", rd_data[31:0]);
    end
    n_run++;
    if (rd_data[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL reset_r5: got %h want 00000000", rd_data[63:32]);
    end
    n_run++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy: got %b want 00", rd_busy);
    end
    n_run++;
    if ({wr0_ready, wr1_ready, alloc_ready} !== 3'b111) begin
      n_fail++; $display("FAIL run_ready: got %b want 111", {wr0_ready, wr1_ready, alloc_ready});
    end
  endtask

  task automatic test_wr_conflict();
    idle(); rd_idx = {5'd0, 5'd7};
    wr0_valid = 1; wr0_idx = 7; wr0_data = 32'hAAAA_0001;
    wr1_valid = 1; wr1_idx = 7; wr1_data = 32'hBBBB_0002;
    #1;
    n_run++;
    if ({wr0_ready, wr1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL conflict_ready: got %b want 10", {wr0_ready, wr1_ready});
    end
    tick();
    wr0_valid = 0;
    #1;
    n_run++;
    if (wr1_ready !== 1'b1) begin
      n_fail++; $display("FAIL conflict_retry_ready: got %b want 1", wr1_ready);
    end
    n_run++;
    if (rd_data[31:0] !== (BYP ? 32'hBBBB_0002 : 32'hAAAA_0001)) begin
      n_fail++; $display("FAIL conflict_r7_a: got %h want %h", rd_data[31:0],
                         BYP ? 32'hBBBB_0002 : 32'hAAAA_0001);
    end
    tick();
    idle();
    #1;
    n_run++;
    if (rd_data[31:0] !== 32'hBBBB_0002) begin
      n_fail++; $display("FAIL conflict_r7_b: got %h want bbbb0002", rd_data[31:0]);
    end
  endtask

  task automatic test_alloc();
    idle(); rd_idx = {5'd0, 5'd9};
    alloc_valid = 1; alloc_idx = 9;
    #1;
    n_run++;
    if (alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL alloc_first_ready: got %b want 1", alloc_ready);
    end
    tick();
    #1;
    n_run++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL alloc_busy: got %b want 1", rd_busy[0]);
    end
    n_run++;
    if (alloc_ready !== 1'b0) begin
      n_fail++; $display("FAIL alloc_waw_stall: got %b want 0", alloc_ready);
    end
    tick();
    idle();
    wr0_valid = 1; wr0_idx = 9; wr0_data = 32'h1234;
    #1;
    n_run++;
    if (rd_busy[0] !== (BYP ? 1'b0 : 1'b1)) begin
      n_fail++; $display("FAIL alloc_busy_during_wr: got %b want %b", rd_busy[0], !BYP);
    end
    tick();
    idle();
    #1;
    n_run++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL alloc_busy_clear: got %b want 0", rd_busy[0]);
    end
    n_run++;
    if (rd_data[31:0] !== 32'h1234) begin
      n_fail++; $display("FAIL alloc_r9_data: got %h want 00001234", rd_data[31:0]);
    end
  endtask

  task automatic test_alloc_write_same();
    idle(); rd_idx = {5'd0, 5'd9};
    alloc_valid = 1; alloc_idx = 9;
    wr0_valid = 1; wr0_idx = 9; wr0_data = 32'h55;
    #1;
    n_run++;
    if (alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL same_alloc_ready: got %b want 1", alloc_ready);
    end
    tick();
    idle();
    #1;
    n_run++;
    if (rd_data[31:0] !== 32'h55) begin
      n_fail++; $display("FAIL same_r9_data: got %h want 00000055", rd_data[31:0]);
    end
    n_run++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL same_r9_busy: got %b want 1", rd_busy[0]);
    end
  endtask

  task automatic test_zero();
    idle(); rd_idx = {5'd0, 5'd0};
    wr0_valid = 1; wr0_idx = 0; wr0_data = 32'hFFFF_FFFF;
    alloc_valid = 1; alloc_idx = 0;
    #1;
    n_run++;
    if ({wr0_ready, alloc_ready} !== 2'b11) begin
      n_fail++; $display("FAIL zero_ready: got %b want 11", {wr0_ready, alloc_ready});
    end
    n_run++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_bypass: got %h want 00000000", rd_data[31:0]);
    end
    tick();
    idle();
    #1;
    n_run++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_data: got %h want 00000000", rd_data[31:0]);
    end
    n_run++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_busy: got %b want 0", rd_busy[0]);
    end
  endtask

  task automatic test_flush();
    idle(); rd_idx = {5'd4, 5'd3};
    alloc_valid = 1; alloc_idx = 3;
    tick();
    alloc_idx = 4;
    tick();
    idle();
    #1;
    n_run++;
    if (rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL flush_pre_busy: got %b want 11", rd_busy);
    end
    // flush with a concurrent alloc (overridden) and a write (kept)
    flush = 1; alloc_valid = 1; alloc_idx = 5;
    wr0_valid = 1; wr0_idx = 6; wr0_data = 32'h66;
    tick();
    idle();
    #1;
    n_run++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL flush_busy: got %b want 00", rd_busy);
    end
    rd_idx = {5'd6, 5'd5};
    #1;
    n_run++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL flush_over_alloc: got %b want 0", rd_busy[0]);
    end
    n_run++;
    if (rd_data[63:32] !== 32'h66) begin
      n_fail++; $display("FAIL flush_wr_data: got %h want 00000066", rd_data[63:32]);
    end
  endtask

  task automatic test_bypass();
    idle(); rd_idx = {5'd0, 5'd3};
    wr0_valid = 1; wr0_idx = 3; wr0_data = 32'hABCD;
    #1;
    n_run++;
    if (rd_data[31:0] !== (BYP ? 32'hABCD : 32'h0)) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h want %h", rd_data[31:0],
                         BYP ? 32'hABCD : 32'h0);
    end
    tick();
    idle();
    #1;
    n_run++;
    if (rd_data[31:0] !== 32'hABCD) begin
      n_fail++; $display("FAIL bypass_next_cycle: got %h want 0000abcd", rd_data[31:0]);
    end
  endtask

  task automatic test_reset_priority();
    idle(); rd_idx = {5'd2, 5'd3};
    rstn = 0;
    wr0_valid = 1; wr0_idx = 2; wr0_data = 32'h1111;
    alloc_valid = 1; alloc_idx = 3;
    tick();
    rstn = 1; idle();
    #1;
    n_run++;
    if (rd_data !== {32'h8000_0000, 32'h0}) begin
      n_fail++; $display("FAIL rstprio_data: got %h want 8000000000000000", rd_data);
    end
    n_run++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL rstprio_busy: got %b want 00", rd_busy);
    end
  endtask

  initial begin
    rd_idx = '0;
    test_reset();
    test_wr_conflict();
    test_alloc();
    test_alloc_write_same();
    test_zero();
    test_flush();
    test_bypass();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
